// File: rtl/rice_core_trap_ctrl.sv
// ---------------------------------------------------------------------------
// rice_core_trap_ctrl
//   Machine-mode trap / CSR controller for the rice core. Takes exceptions,
//   mret and the execute-stage pc, and returns the privilege level, trap
//   target and return target. Holds the M-mode trap CSRs plus the 64-bit
//   mcycle / minstret counters and serves one CSR access per cycle with a
//   combinational read path. Supports M and U privilege modes.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_exception_valid/_code/_value  trap request, cause code, trap value
//   i_mret                      mret executed this cycle
//   i_pc                        pc of the instruction in execute
//   i_retire                    instruction retired (minstret increment)
//   i_csr_valid/_address/_op/_wdata  CSR access (op: 00 RD 01 RW 10 RS 11 RC)
//   o_csr_rdata, o_csr_illegal  old CSR value (0 if illegal), reject flag
//   o_privilege_level           2'b11 M, 2'b00 U
//   o_trap_pc, o_return_pc      mtvec base, mepc
// ---------------------------------------------------------------------------
module rice_core_trap_ctrl #(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_TVEC = 32'h0000_0000,
  parameter logic [XLEN-1:0]  MISA_VALUE = 32'h4010_0100
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_exception_valid,
  input  logic [3:0]      i_exception_code,
  input  logic [XLEN-1:0] i_exception_value,
  input  logic            i_mret,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_retire,
  input  logic            i_csr_valid,
  input  logic [11:0]     i_csr_address,
  input  logic [1:0]      i_csr_op,
  input  logic [XLEN-1:0] i_csr_wdata,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  output logic [1:0]      o_privilege_level,
  output logic [XLEN-1:0] o_trap_pc,
  output logic [XLEN-1:0] o_return_pc
);

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [1:0]      r_priv;
  logic            r_mie;
  logic            r_mpie;
  logic [1:0]      r_mpp;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [3:0]      r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;

  logic            w_mapped;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic            w_is_write;
  logic            w_illegal;
  logic            w_mret_take;
  logic            w_wr_en;

  // Only M (11) and U (00) are supported; 01/10 fall back to U.
  function automatic logic [1:0] warl_mpp(input logic [1:0] v);
    return (v == PRIV_M) ? PRIV_M : PRIV_U;
  endfunction

  // CSR address decode and old-value mux.
  always_comb begin
    w_mapped = 1'b1;
    w_old    = 32'h0000_0000;
    case (i_csr_address)
      12'h300: w_old = {19'd0, r_mpp, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
      12'h301: w_old = MISA_VALUE;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = {28'd0, r_mcause};
      12'h343: w_old = r_mtval;
      12'hB00: w_old = r_mcycle[31:0];
      12'hB80: w_old = r_mcycle[63:32];
      12'hB02: w_old = r_minstret[31:0];
      12'hB82: w_old = r_minstret[63:32];
      12'hF14: w_old = 32'h0000_0000;
      default: w_mapped = 1'b0;
    endcase
  end

  assign w_is_write = (i_csr_op != 2'b00);
  // misa is read-only even though its address lies in the read/write range.
  assign w_illegal  = i_csr_valid &
                      (~w_mapped |
                       (w_is_write & ((i_csr_address[11:10] == 2'b11) |
                                      (i_csr_address == 12'h301))) |
                       (r_priv < i_csr_address[9:8]));

  // New value for the addressed CSR before WARL masking.
  always_comb begin
    case (i_csr_op)
      2'b01:   w_new = i_csr_wdata;
      2'b10:   w_new = w_old | i_csr_wdata;
      2'b11:   w_new = w_old & ~i_csr_wdata;
      default: w_new = w_old;
    endcase
  end

  assign w_mret_take = i_mret & (r_priv == PRIV_M);
  // Exception and a taken mret both suppress the CSR write.
  assign w_wr_en     = i_csr_valid & w_is_write & ~w_illegal &
                       ~i_exception_valid & ~w_mret_take;

  assign o_csr_illegal     = w_illegal;
  assign o_csr_rdata       = (i_csr_valid & ~w_illegal) ? w_old : 32'h0000_0000;
  assign o_privilege_level = r_priv;
  assign o_trap_pc         = r_mtvec & ALIGN_MASK;
  assign o_return_pc       = r_mepc;

  // Trap state, CSR writes and counters; a counter write overrides the increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_priv     <= PRIV_M;
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mpp      <= PRIV_M;
      r_mtvec    <= RESET_TVEC & ALIGN_MASK;
      r_mscratch <= 32'h0000_0000;
      r_mepc     <= 32'h0000_0000;
      r_mcause   <= 4'd0;
      r_mtval    <= 32'h0000_0000;
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
      if (i_retire && !i_exception_valid) begin
        r_minstret <= r_minstret + 64'd1;
      end
      if (i_exception_valid) begin
        r_mepc   <= i_pc & ALIGN_MASK;
        r_mcause <= i_exception_code;
        r_mtval  <= i_exception_value;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mpp    <= r_priv;
        r_priv   <= PRIV_M;
      end else if (w_mret_take) begin
        r_priv <= r_mpp;
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
        r_mpp  <= PRIV_U;
      end else if (w_wr_en) begin
        case (i_csr_address)
          12'h300: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
            r_mpp  <= warl_mpp(w_new[12:11]);
          end
          12'h305: r_mtvec    <= w_new & ALIGN_MASK;
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= w_new & ALIGN_MASK;
          12'h342: r_mcause   <= w_new[3:0];
          12'h343: r_mtval    <= w_new;
          12'hB00: r_mcycle   <= {r_mcycle[63:32], w_new};
          12'hB80: r_mcycle   <= {w_new, r_mcycle[31:0]};
          12'hB02: r_minstret <= {r_minstret[63:32], w_new};
          12'hB82: r_minstret <= {w_new, r_minstret[31:0]};
          default: r_mscratch <= r_mscratch;
        endcase
      end else begin
        r_priv <= r_priv;
      end
    end
  end

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rice_core_trap_ctrl
//   Directed scenarios followed by random traffic, all compared against an
//   architectural model of the trap CSRs (whole-word mstatus, 64-bit counters).
// ---------------------------------------------------------------------------
module tb_rice_core_trap_ctrl;

  localparam logic [31:0] TVEC = 32'h0000_1003;
  localparam logic [31:0] MISA = 32'h4010_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_v = 1'b0;
  logic [3:0]  exc_c = 4'd0;
  logic [31:0] exc_val = 32'd0;
  logic        mret = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        retire = 1'b0;
  logic        cv = 1'b0;
  logic [11:0] caddr = 12'd0;
  logic [1:0]  cop = 2'd0;
  logic [31:0] cwd = 32'd0;
  logic [31:0] rdata;
  logic        illegal;
  logic [1:0]  priv;
  logic [31:0] trap_pc;
  logic [31:0] ret_pc;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rdata;
  logic        last_illegal;

  // model state
  logic [1:0]  m_priv;
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  rice_core_trap_ctrl #(.XLEN(32), .RESET_TVEC(TVEC), .MISA_VALUE(MISA)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_exception_valid(exc_v), .i_exception_code(exc_c), .i_exception_value(exc_val),
    .i_mret(mret), .i_pc(pc), .i_retire(retire),
    .i_csr_valid(cv), .i_csr_address(caddr), .i_csr_op(cop), .i_csr_wdata(cwd),
    .o_csr_rdata(rdata), .o_csr_illegal(illegal), .o_privilege_level(priv),
    .o_trap_pc(trap_pc), .o_return_pc(ret_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_priv = 2'b11; m_mstatus = 32'h0000_1800; m_mtvec = TVEC & 32'hFFFF_FFFC;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cycle = 64'd0; m_instret = 64'd0;
  endtask

  // {mapped, value}
  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, m_mstatus};
      12'h301: return {1'b1, MISA};
      12'h305: return {1'b1, m_mtvec};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'h343: return {1'b1, m_mtval};
      12'hB00: return {1'b1, m_cycle[31:0]};
      12'hB80: return {1'b1, m_cycle[63:32]};
      12'hB02: return {1'b1, m_instret[31:0]};
      12'hB82: return {1'b1, m_instret[63:32]};
      12'hF14: return {1'b1, 32'd0};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  function automatic logic m_illegal(input logic v, input logic [11:0] a, input logic [1:0] op);
    logic [32:0] r;
    logic ro;
    r  = m_read(a);
    ro = (a[11:10] == 2'b11) || (a == 12'h301);
    if (!v) return 1'b0;
    return !r[32] || (op != 2'b00 && ro) || (m_priv < a[9:8]);
  endfunction

  task automatic model_step(input logic e, input logic [3:0] code, input logic [31:0] val,
                            input logic mr, input logic [31:0] p, input logic ret,
                            input logic v, input logic [11:0] a, input logic [1:0] op,
                            input logic [31:0] wd);
    logic [31:0] old, nv;
    logic [63:0] c, n;
    logic ill;
    old = m_read(a) >> 0;
    ill = m_illegal(v, a, op);
    case (op)
      2'd1: nv = wd;
      2'd2: nv = old | wd;
      2'd3: nv = old & ~wd;
      default: nv = old;
    endcase
    c = m_cycle + 64'd1;
    n = m_instret + ((ret && !e) ? 64'd1 : 64'd0);
    if (e) begin
      m_mepc = p & 32'hFFFF_FFFC; m_mcause = {28'd0, code}; m_mtval = val;
      m_mstatus[7] = m_mstatus[3]; m_mstatus[3] = 1'b0;
      m_mstatus[12:11] = m_priv; m_priv = 2'b11;
    end else if (mr && m_priv == 2'b11) begin
      m_priv = m_mstatus[12:11]; m_mstatus[3] = m_mstatus[7];
      m_mstatus[7] = 1'b1; m_mstatus[12:11] = 2'b00;
    end else if (v && op != 2'd0 && !ill) begin
      case (a)
        12'h300: begin
          nv = nv & 32'h0000_1888;
          if (nv[12:11] == 2'b01 || nv[12:11] == 2'b10) nv[12:11] = 2'b00;
          m_mstatus = nv;
        end
        12'h305: m_mtvec = nv & 32'hFFFF_FFFC;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & 32'hFFFF_FFFC;
        12'h342: m_mcause = nv & 32'h0000_000F;
        12'h343: m_mtval = nv;
        12'hB00: c = {m_cycle[63:32], nv};
        12'hB80: c = {nv, m_cycle[31:0]};
        12'hB02: n = {m_instret[63:32], nv};
        12'hB82: n = {nv, m_instret[31:0]};
        default: ;
      endcase
    end
    m_cycle = c; m_instret = n;
  endtask

  // One clock: drive, check combinational CSR path, clock, check registered outputs.
  task automatic do_cycle(input logic e, input logic [3:0] code, input logic [31:0] val,
                          input logic mr, input logic [31:0] p, input logic ret,
                          input logic v, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd);
    logic [32:0] r;
    logic ill;
    exc_v = e; exc_c = code; exc_val = val; mret = mr; pc = p; retire = ret;
    cv = v; caddr = a; cop = op; cwd = wd;
    #1;
    r   = m_read(a);
    ill = m_illegal(v, a, op);
    last_rdata = rdata; last_illegal = illegal;
    check_eq("csr_illegal", {63'd0, illegal}, {63'd0, ill});
    check_eq("csr_rdata", {32'd0, rdata}, {32'd0, (v && !ill) ? r[31:0] : 32'd0});
    @(posedge clk);
    model_step(e, code, val, mr, p, ret, v, a, op, wd);
    #1;
    check_eq("priv", {62'd0, priv}, {62'd0, m_priv});
    check_eq("trap_pc", {32'd0, trap_pc}, {32'd0, m_mtvec});
    check_eq("return_pc", {32'd0, ret_pc}, {32'd0, m_mepc});
  endtask

  task automatic rd(input logic [11:0] a);
    do_cycle(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, a, 2'b00, 32'd0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    do_cycle(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, a, op, d);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_rst_priv", {62'd0, priv}, 64'd3);
    check_eq("async_rst_trap", {32'd0, trap_pc}, 64'h1000);
    check_eq("async_rst_ret", {32'd0, ret_pc}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [11:0] addr_tbl [12] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_priv", {62'd0, priv}, 64'd3);
    check_eq("rst_trap_pc", {32'd0, trap_pc}, 64'h1000);
    check_eq("rst_return_pc", {32'd0, ret_pc}, 64'd0);
    rst_n = 1'b1;

    rd(12'h300); check_eq("rst_mstatus", {32'd0, last_rdata}, 64'h1800);
    rd(12'h305); check_eq("rst_mtvec", {32'd0, last_rdata}, 64'h1000);
    rd(12'hF14); check_eq("mhartid", {32'd0, last_rdata}, 64'd0);

    // trap entry
    wr(12'h300, 2'b10, 32'h0000_0008);
    wr(12'h305, 2'b01, 32'h8000_0103);
    do_cycle(1'b1, 4'd2, 32'h0000_DEAD, 1'b0, 32'h0000_0102, 1'b1, 1'b0, 12'h0, 2'b00, 32'd0);
    check_eq("trap_pc_val", {32'd0, trap_pc}, 64'h8000_0100);
    check_eq("mepc_val", {32'd0, ret_pc}, 64'h100);
    rd(12'h342); check_eq("mcause", {32'd0, last_rdata}, 64'd2);
    rd(12'h343); check_eq("mtval", {32'd0, last_rdata}, 64'hDEAD);
    rd(12'h300); check_eq("mstatus_trap", {32'd0, last_rdata}, 64'h1880);

    // mret to U, then U-mode access
    wr(12'h300, 2'b11, 32'h0000_1800);
    do_cycle(1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 12'h0, 2'b00, 32'd0);
    check_eq("mret_priv_u", {62'd0, priv}, 64'd0);
    check_eq("mret_ret_pc", {32'd0, ret_pc}, 64'h100);
    rd(12'h300);
    check_eq("u_read_illegal", {63'd0, last_illegal}, 64'd1);
    check_eq("u_read_rdata", {32'd0, last_rdata}, 64'd0);
    do_cycle(1'b0, 4'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 12'h0, 2'b00, 32'd0);
    check_eq("mret_in_u_ignored", {62'd0, priv}, 64'd0);

    // trap from U, then exception + mret + CSR write together
    do_cycle(1'b1, 4'd8, 32'd0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 12'h0, 2'b00, 32'd0);
    rd(12'h300); check_eq("mpp_from_u", {32'd0, last_rdata}, 64'h0080);
    do_cycle(1'b1, 4'd3, 32'h55, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 12'h340, 2'b01, 32'h1234);
    check_eq("prio_priv", {62'd0, priv}, 64'd3);
    check_eq("prio_mepc", {32'd0, ret_pc}, 64'h300);
    rd(12'h340); check_eq("prio_mscratch", {32'd0, last_rdata}, 64'd0);

    // counter carry and write-wins
    wr(12'hB80, 2'b01, 32'd0);
    wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
    rd(12'hB00); check_eq("mcycle_no_inc", {32'd0, last_rdata}, 64'hFFFF_FFFF);
    rd(12'hB80); check_eq("mcycleh_carry", {32'd0, last_rdata}, 64'd1);
    wr(12'hB02, 2'b01, 32'h10);
    do_cycle(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 12'hB02, 2'b00, 32'd0);
    check_eq("minstret_wr", {32'd0, last_rdata}, 64'h10);

    // read-only and WARL
    wr(12'h301, 2'b01, 32'h0);
    check_eq("misa_wr_illegal", {63'd0, last_illegal}, 64'd1);
    rd(12'h301); check_eq("misa_val", {32'd0, last_rdata}, {32'd0, MISA});
    wr(12'h300, 2'b10, 32'h0000_1888);
    check_eq("rs_mstatus_legal", {63'd0, last_illegal}, 64'd0);
    rd(12'h300); check_eq("mstatus_rs", {32'd0, last_rdata}, 64'h1888);
    wr(12'h300, 2'b01, 32'hFFFF_EFFF);
    rd(12'h300); check_eq("mpp_warl", {32'd0, last_rdata}, 64'h0088);
    wr(12'h342, 2'b01, 32'hFFFF_FFFF);
    rd(12'h342); check_eq("mcause_warl", {32'd0, last_rdata}, 64'hF);
    wr(12'hF14, 2'b10, 32'h1);
    check_eq("mhartid_wr_illegal", {63'd0, last_illegal}, 64'd1);
    wr(12'h7C0, 2'b00, 32'h0);
    check_eq("unmapped_illegal", {63'd0, last_illegal}, 64'd1);

    // random traffic with one reset in the middle
    for (int i = 0; i < 600; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      if (i == 300) begin
        mid_reset();
        rd(12'hB00);
        check_eq("post_rst_mcycle", {32'd0, last_rdata}, 64'd0);
      end
      a = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(0, 11)];
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      do_cycle($urandom_range(0, 15) == 0, 4'($urandom), $urandom,
               $urandom_range(0, 7) == 0, $urandom, 1'($urandom),
               $urandom_range(0, 3) != 0, a, 2'($urandom), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
